// File: rtl/fix_checksum_stream.sv
// Streaming FIX checksum engine.
// Sums every message byte from BeginString up to and including the SOH that
// precedes the "10=" trailer, decodes the received decimal checksum and
// reports both values with a match flag and error status once per message.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   data_i/valid_i    message byte stream (accepted when valid_i && ready_o)
//   sop_i/eop_i       first/last byte markers, qualified by valid_i
//   ready_o           byte accepted this cycle (low while a result is pending)
//   res_valid_o       result available; held until res_ready_i
//   res_ready_i       downstream accepts the result
//   checksum_o        computed checksum (mod 2^SUM_W)
//   rx_checksum_o     decoded received checksum, saturated to 2^SUM_W-1
//   match_o           checksums equal and no error
//   err_o             [0] format, [1] length overflow, [2] aborted by sop
//   len_o             bytes accepted, sop through eop inclusive
module fix_checksum_stream #(
    parameter logic [7:0]  SOH_CHAR   = 8'h01,
    parameter int unsigned SUM_W      = 8,
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned MAX_LEN    = 4096,
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             sop_i,
    input  logic             eop_i,
    output logic             ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [SUM_W-1:0] checksum_o,
    output logic [SUM_W-1:0] rx_checksum_o,
    output logic             match_o,
    output logic [2:0]       err_o,
    output logic [LEN_W-1:0] len_o
);

    localparam int unsigned DIG_W = $clog2(NUM_DIGITS + 2);
    localparam int unsigned RXW_W = SUM_W + 4;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_EQ = 8'h3D;

    typedef enum logic [2:0] {
        S_IDLE, S_BODY, S_T1, S_T0, S_TEQ, S_DIG, S_RESULT
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   snap;
    logic [SUM_W-1:0]   frozen;
    logic [SUM_W-1:0]   rx_acc;
    logic [DIG_W-1:0]   ndig;
    logic [LEN_W-1:0]   len;
    logic [2:0]         err_acc;
    logic [7:0]         skid_data;
    logic               skid_vld;

    logic               accept;
    logic               is_digit;
    logic [SUM_W-1:0]   sum_add;
    logic [RXW_W-1:0]   rx_wide;
    logic [SUM_W-1:0]   rx_sat;
    logic [LEN_W-1:0]   len_inc;
    logic [DIG_W-1:0]   ndig_inc;

    logic               fin;
    logic [SUM_W-1:0]   fin_sum;
    logic [SUM_W-1:0]   fin_rx;
    logic [2:0]         fin_err;
    logic [LEN_W-1:0]   fin_len;
    logic               fin_match;

    // Datapath helpers: modulo sum, decimal shift-in with saturation, saturating counters
    assign accept   = valid_i && ready_o;
    assign is_digit = (data_i >= CH_0) && (data_i <= CH_9);
    assign sum_add  = sum + SUM_W'(data_i);
    assign rx_wide  = RXW_W'(rx_acc) * RXW_W'(10) + RXW_W'(data_i[3:0]);
    assign rx_sat   = (|rx_wide[RXW_W-1:SUM_W]) ? {SUM_W{1'b1}} : rx_wide[SUM_W-1:0];
    assign len_inc  = (len == LEN_W'(MAX_LEN)) ? len : len + LEN_W'(1);
    assign ndig_inc = (ndig > DIG_W'(NUM_DIGITS)) ? ndig : ndig + DIG_W'(1);

    // Result payload for the cycle a message closes (eop, abort, or sop+eop)
    always_comb begin
        fin     = 1'b0;
        fin_sum = sum_add;
        fin_rx  = rx_acc;
        fin_err = err_acc;
        fin_len = len_inc;
        if (state != S_RESULT && accept) begin
            if (sop_i && state != S_IDLE) begin
                // Aborted message: report what was gathered, sop byte goes to skid
                fin     = 1'b1;
                fin_sum = (state == S_DIG) ? frozen : sum;
                fin_len = len;
                fin_err = err_acc | 3'b100;
            end else if (sop_i && eop_i) begin
                fin     = 1'b1;
                fin_sum = SUM_W'(data_i);
                fin_rx  = '0;
                fin_len = LEN_W'(1);
                fin_err = 3'b001;
            end else if (eop_i && state != S_IDLE) begin
                fin = 1'b1;
                if (state == S_DIG) begin
                    fin_sum = frozen;
                    fin_err = err_acc | {2'b00, (data_i != SOH_CHAR) ||
                                                (ndig != DIG_W'(NUM_DIGITS))};
                end else begin
                    fin_err = err_acc | 3'b001;
                end
            end
        end
        fin_match = (fin_sum == fin_rx) && (fin_err == 3'b000);
    end

    // Message FSM, working accumulators and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            sum           <= '0;
            snap          <= '0;
            frozen        <= '0;
            rx_acc        <= '0;
            ndig          <= '0;
            len           <= '0;
            err_acc       <= '0;
            skid_data     <= '0;
            skid_vld      <= 1'b0;
            ready_o       <= 1'b0;
            res_valid_o   <= 1'b0;
            checksum_o    <= '0;
            rx_checksum_o <= '0;
            match_o       <= 1'b0;
            err_o         <= '0;
            len_o         <= '0;
        end else if (state == S_RESULT) begin
            ready_o <= res_ready_i;
            if (res_ready_i) begin
                res_valid_o <= 1'b0;
                if (skid_vld) begin
                    // Restart the aborting message from the held sop byte
                    state    <= S_BODY;
                    sum      <= SUM_W'(skid_data);
                    len      <= LEN_W'(1);
                    err_acc  <= '0;
                    rx_acc   <= '0;
                    skid_vld <= 1'b0;
                end else begin
                    state <= S_IDLE;
                end
            end
        end else if (fin) begin
            state         <= S_RESULT;
            ready_o       <= 1'b0;
            res_valid_o   <= 1'b1;
            checksum_o    <= fin_sum;
            rx_checksum_o <= fin_rx;
            match_o       <= fin_match;
            err_o         <= fin_err;
            len_o         <= fin_len;
            if (sop_i && state != S_IDLE) begin
                skid_data <= data_i;
                skid_vld  <= 1'b1;
            end
        end else begin
            ready_o <= 1'b1;
            if (accept) begin
                if (state == S_IDLE) begin
                    if (sop_i) begin
                        state   <= S_BODY;
                        sum     <= SUM_W'(data_i);
                        len     <= LEN_W'(1);
                        err_acc <= '0;
                        rx_acc  <= '0;
                    end
                end else if (!err_acc[1]) begin
                    // Once overflowed, bytes are dropped until eop or sop
                    len <= len_inc;
                    if (len_inc == LEN_W'(MAX_LEN)) begin
                        err_acc[1] <= 1'b1;
                    end
                    if (state == S_DIG) begin
                        if (is_digit) begin
                            rx_acc <= rx_sat;
                            ndig   <= ndig_inc;
                        end else if (data_i != SOH_CHAR) begin
                            err_acc[0] <= 1'b1;
                        end
                    end else begin
                        sum <= sum_add;
                        if (data_i == SOH_CHAR) begin
                            snap  <= sum_add;
                            state <= S_T1;
                        end else begin
                            case (state)
                                S_T1:    state <= (data_i == CH_1) ? S_T0 : S_BODY;
                                S_T0:    state <= (data_i == CH_0) ? S_TEQ : S_BODY;
                                S_TEQ: begin
                                    if (data_i == CH_EQ) begin
                                        frozen <= snap;
                                        rx_acc <= '0;
                                        ndig   <= '0;
                                        state  <= S_DIG;
                                    end else begin
                                        state <= S_BODY;
                                    end
                                end
                                default: state <= S_BODY;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/fix_checksum_stream.md
Name: fix_checksum_stream

Overview:
- Parametrised streaming FIX checksum engine with ready/valid on both input and result.
- Sums every byte from BeginString ('8') through the SOH that precedes the "10=" trailer tag. Arithmetic is modulo 2^SUM_W.
- Parses the received 3-digit ASCII checksum and compares it against the computed value.
- Sits between the byte deframer and the FIX field parser. Reports checksum, match and error status once per message.

Parameters:
- SOH_CHAR, 8'h01, field delimiter byte.
- SUM_W, 8, checksum accumulator width; the sum is taken mod 2^SUM_W.
- NUM_DIGITS, 3, number of ASCII decimal digits in the trailer value.
- MAX_LEN, 4096, maximum message length in bytes; len counter width is clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  8  message byte.
- valid_i  in  1  data_i valid.
- sop_i  in  1  first byte of message; qualified by valid_i.
- eop_i  in  1  last byte of message (final SOH); qualified by valid_i.
- ready_o  out  1  block accepts a byte this cycle.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  downstream accepts result.
- checksum_o  out  SUM_W  computed checksum.
- rx_checksum_o  out  SUM_W  decoded received value, saturated to 2^SUM_W-1.
- match_o  out  1  checksum_o == rx_checksum_o and err_o == 0.
- err_o  out  3  [0] format, [1] length overflow, [2] aborted by sop.
- len_o  out  clog2(MAX_LEN+1)  bytes accepted, sop through eop inclusive.

Behaviour:
- Reset: asynchronous on rst=0. All outputs are 0; state is IDLE; accumulators are cleared. Reset mid-message discards the message and emits no result.
- A byte is accepted when valid_i && ready_o. ready_o=1 in every state except RESULT.
- States and transitions:
  - IDLE: ignore bytes without sop_i. On accepted sop byte: sum=data_i, len=1, go to BODY.
  - BODY: sum += byte. If byte==SOH_CHAR: snap=new sum, go to T1.
  - T1: byte '1' goes to T0; otherwise go to BODY.
  - T0: byte '0' goes to TEQ; otherwise go to BODY.
  - TEQ: byte '=' freezes checksum=snap, rx=0, ndig=0, and goes to DIG; otherwise go to BODY.
  - In T1, T0 and TEQ every byte is still added to sum. An SOH in any of these states takes a new snap and returns to T1.
  - DIG: a digit byte does rx=rx*10+(byte-'0') and ndig++. A non-digit other than SOH sets err[0]. eop on SOH: err[0] |= (ndig!=NUM_DIGITS), then go to RESULT.
- Any eop in a state other than DIG: checksum=current sum, err[0]=1, go to RESULT.
- sop and eop on the same byte: err[0]=1, len=1, go to RESULT.
- sop while not IDLE or RESULT: the current message is reported in RESULT with err[2]=1. The sop byte is held in a one-byte skid register and restarts the message on exit from RESULT. ready_o is low until the skid is consumed.
- len reaching MAX_LEN without eop: err[1]=1. Further bytes are dropped until eop or sop; the counter saturates.
- RESULT: res_valid_o=1 and all result outputs stable. Exit on res_ready_i: go to IDLE, or to BODY if the skid is loaded. Earliest res_valid_o is the cycle after the eop byte is accepted.
- Wrap-around: the sum uses a modulo-2^SUM_W add. rx uses a SUM_W+4-bit intermediate and saturates.
- Result outputs hold their value until the next result. match_o is registered together with res_valid_o.

Test Plan:
- "8=A\x01" + "10=183\x01" with eop on last SOH, res_ready_i=1 -> res_valid_o one cycle after eop, checksum_o=183, rx=183, match_o=1, err_o=0, len_o=11.
- Same message with "10=184\x01" -> checksum_o=183, rx=184, match_o=0, err_o=0.
- "8=FIX.4.2\x01" + "10=031\x01" -> checksum_o=31 (543 mod 256), match_o=1. Exercises wrap-around and a leading-zero digit.
- "8=A\x01101=Z\x01" + "10=225\x01" -> the "101=" tag is summed as body, checksum_o=225, match_o=1.
- Mid-body sop, and res_ready_i held 0 for 5 cycles -> first result err_o=3'b100, ready_o=0 until acknowledged. The second message completes correctly from the skid byte.
- rst pulsed low mid-DIG, then a clean message -> outputs zero during reset, no spurious res_valid_o, second result correct. Also eop after "10=18" -> err_o[0]=1.
